vga_timing_frame: RTL and testbench

VGA_TIMING_FRAME -- requirements
Module: vga_timing_frame

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/wrap_counter.sv | 41 ++++
 rtl/vga_timing_frame.sv | 112 +++++++++++
 tb/tb_vga_timing_frame.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, band state type and window-decode helper
// for the VGA frame timing generator.
package vga_timing_pkg;

  localparam int unsigned H_FRONT = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BACK  = 48;
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_FRONT = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BACK  = 33;
  localparam int unsigned V_TOTAL = 525;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned FRAME_W = 11;

  // Each sync pulse starts right after the visible area plus the front porch.
  localparam int unsigned H_VISIBLE = H_TOTAL - H_FRONT - H_SYNC - H_BACK;
  localparam int unsigned V_VISIBLE = V_TOTAL - V_FRONT - V_SYNC - V_BACK;
  localparam int unsigned HS_FIRST  = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_LAST   = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST  = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_LAST   = VS_FIRST + V_SYNC - 1;

  localparam int unsigned H_LAST = H_TOTAL - 1;
  localparam int unsigned V_LAST = V_TOTAL - 1;

  typedef enum logic [1:0] {
    BAND_0 = 2'd0,
    BAND_1 = 2'd1,
    BAND_2 = 2'd2,
    BAND_3 = 2'd3
  } band_e;

  function automatic logic in_window(input logic [POS_W-1:0] pos,
                                     input int unsigned      lo,
                                     input int unsigned      hi);
    return (pos >= POS_W'(lo)) && (pos <= POS_W'(hi));
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(LAST+1) up-counter with increment enable and a same-cycle wrap pulse,
// used for both the pixel column and the line counters.
module wrap_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LAST  = 799
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_last;

  assign at_last = (count_q == LAST_V);
  assign wrap_o  = inc_i & at_last;
  assign count_o = count_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = at_last ? '0 : count_q + ONE_V;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_frame.sv
// VGA 800x525 frame timing: column/line counters, frame counter, vertical band
// register and zero-latency sync/visibility/strobe decodes.
module vga_timing_frame
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BAND_H   = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_start,
  output logic               line_start,
  output logic [1:0]         band,
  output logic               grad_step
);

  // Band boundaries built by addition so no multiplier is implied.
  localparam int unsigned BAND_1_LINE = BAND_H;
  localparam int unsigned BAND_2_LINE = BAND_1_LINE + BAND_H;
  localparam int unsigned BAND_3_LINE = BAND_2_LINE + BAND_H;

  localparam logic [POS_W-1:0]   H_ACT_V = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0]   V_ACT_V = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0]   B1_V    = POS_W'(BAND_1_LINE);
  localparam logic [POS_W-1:0]   B2_V    = POS_W'(BAND_2_LINE);
  localparam logic [POS_W-1:0]   B3_V    = POS_W'(BAND_3_LINE);
  localparam logic [POS_W-1:0]   B1_PRE  = POS_W'(BAND_1_LINE - 1);
  localparam logic [POS_W-1:0]   B2_PRE  = POS_W'(BAND_2_LINE - 1);
  localparam logic [POS_W-1:0]   B3_PRE  = POS_W'(BAND_3_LINE - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  logic               h_wrap;
  logic               v_wrap;
  logic [FRAME_W-1:0] frame_q, frame_d;
  band_e              band_q, band_d;
  logic               band_edge_line;

  wrap_counter #(
    .WIDTH (POS_W),
    .LAST  (H_LAST)
  ) u_hcnt (
    .clk     (clk),
    .rst     (reset),
    .inc_i   (ena),
    .count_o (hpos),
    .wrap_o  (h_wrap)
  );

  wrap_counter #(
    .WIDTH (POS_W),
    .LAST  (V_LAST)
  ) u_vcnt (
    .clk     (clk),
    .rst     (reset),
    .inc_i   (h_wrap),
    .count_o (vpos),
    .wrap_o  (v_wrap)
  );

  // v_wrap already implies the column wrap, so frame moves with both counters.
  always_comb begin
    frame_d = frame_q;
    if (v_wrap) begin
      frame_d = frame_q + FRAME_ONE;
    end
  end

  // Band steps when the line about to start is a band boundary; 3 is terminal until frame wrap.
  always_comb begin
    band_d = band_q;
    if (v_wrap) begin
      band_d = BAND_0;
    end else if (h_wrap) begin
      case (band_q)
        BAND_0:  if (vpos == B1_PRE) band_d = BAND_1;
        BAND_1:  if (vpos == B2_PRE) band_d = BAND_2;
        BAND_2:  if (vpos == B3_PRE) band_d = BAND_3;
        default: band_d = band_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
      band_q  <= BAND_0;
    end else begin
      frame_q <= frame_d;
      band_q  <= band_d;
    end
  end

  assign band_edge_line = (vpos == '0) || (vpos == B1_V) || (vpos == B2_V) || (vpos == B3_V);

  assign hsync       = ~in_window(hpos, HS_FIRST, HS_LAST);
  assign vsync       = ~in_window(vpos, VS_FIRST, VS_LAST);
  assign display_on  = (hpos < H_ACT_V) && (vpos < V_ACT_V);
  assign line_start  = (hpos == '0);
  assign frame_start = line_start && (vpos == '0);
  assign grad_step   = line_start && !band_edge_line;
  assign frame       = frame_q;
  assign band        = band_q;

endmodule

// File: tb/tb_vga_timing_frame.sv
// Self-checking bench for vga_timing_frame: directed vector table, arithmetic
// reference model driven by random ena, and counter jumps for frame-scale corners.
module tb_vga_timing_frame;
  import vga_timing_pkg::*;

  logic        clk;
  logic        reset;
  logic        ena;
  logic        hsync, vsync, display_on, frame_start, line_start, grad_step;
  logic [9:0]  hpos, vpos;
  logic [10:0] frame;
  logic [1:0]  band;

  int total = 0;
  int bad   = 0;

  logic [9:0]  j_h, j_v;
  logic [10:0] j_f;
  band_e       j_b;

  vga_timing_frame dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .hpos        (hpos),
    .vpos        (vpos),
    .frame       (frame),
    .frame_start (frame_start),
    .line_start  (line_start),
    .band        (band),
    .grad_step   (grad_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   hp;
    int   vp;
    int   fr;
    int   bd;
    logic hs;
    logic vs;
    logic disp;
    logic fs;
    logic ls;
    logic gs;
  } exp_t;

  typedef struct {
    logic rst;
    logic en;
    int   cyc;
    int   hp;
    int   vp;
    logic hs;
    logic ls;
    logic disp;
    logic fs;
  } vec_t;

  // Reference: position derived from the number of advanced pixels since (0,0,frame 0).
  function automatic exp_t model(input longint n);
    exp_t   e;
    longint hp, vp;
    hp     = n % 800;
    vp     = (n / 800) % 525;
    e.hp   = int'(hp);
    e.vp   = int'(vp);
    e.fr   = int'((n / 420000) % 2048);
    e.bd   = (vp >= 360) ? 3 : (vp >= 240) ? 2 : (vp >= 120) ? 1 : 0;
    e.hs   = !(hp >= 656 && hp <= 751);
    e.vs   = !(vp == 490 || vp == 491);
    e.disp = (hp < 640) && (vp < 480);
    e.ls   = (hp == 0);
    e.fs   = (hp == 0) && (vp == 0);
    e.gs   = (hp == 0) && !(vp == 0 || vp == 120 || vp == 240 || vp == 360);
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " hpos"},        hpos,        e.hp);
    check({tag, " vpos"},        vpos,        e.vp);
    check({tag, " frame"},       frame,       e.fr);
    check({tag, " band"},        band,        e.bd);
    check({tag, " hsync"},       hsync,       e.hs);
    check({tag, " vsync"},       vsync,       e.vs);
    check({tag, " display_on"},  display_on,  e.disp);
    check({tag, " frame_start"}, frame_start, e.fs);
    check({tag, " line_start"},  line_start,  e.ls);
    check({tag, " grad_step"},   grad_step,   e.gs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ena   = 1'b0;
    #1;
    tick();
    reset = 1'b0;
  endtask

  // Place the counters at an arbitrary point; the force spans two held edges so the
  // registers themselves end up carrying the value once released.
  task automatic jump(input int h, input int v, input int f, input int b);
    ena = 1'b0;
    j_h = 10'(h);
    j_v = 10'(v);
    j_f = 11'(f);
    j_b = band_e'(b);
    force dut.u_hcnt.count_q = j_h;
    force dut.u_vcnt.count_q = j_v;
    force dut.frame_q        = j_f;
    force dut.band_q         = j_b;
    tick();
    tick();
    release dut.u_hcnt.count_q;
    release dut.u_vcnt.count_q;
    release dut.frame_q;
    release dut.band_q;
    #1;
  endtask

  vec_t   vecs[13];
  longint n;
  int     cnt_a, cnt_b, first_lo, last_lo;
  exp_t   e;

  initial begin
    reset = 1'b1;
    ena   = 1'b0;

    vecs[0]  = '{1'b1, 1'b1,   0,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b1,   3,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0,   3,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1,   1,   1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 638, 639, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1,   1, 640, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0,   7, 640, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1,  16, 656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1,  95, 751, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1,   1, 752, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1,  47, 799, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1,   1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1,   0,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1};

    #2;
    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst;
      ena   = vecs[i].en;
      if (vecs[i].cyc == 0) #1;
      else repeat (vecs[i].cyc) tick();
      check($sformatf("vec%0d hpos", i),        hpos,        vecs[i].hp);
      check($sformatf("vec%0d vpos", i),        vpos,        vecs[i].vp);
      check($sformatf("vec%0d hsync", i),       hsync,       vecs[i].hs);
      check($sformatf("vec%0d line_start", i),  line_start,  vecs[i].ls);
      check($sformatf("vec%0d display_on", i),  display_on,  vecs[i].disp);
      check($sformatf("vec%0d frame_start", i), frame_start, vecs[i].fs);
    end

    // One full line from reset: hsync window and line_start positions.
    do_reset();
    ena      = 1'b1;
    cnt_a    = 0;
    cnt_b    = 0;
    first_lo = -1;
    last_lo  = -1;
    for (int c = 0; c <= 800; c++) begin
      check_all("line", model(c));
      if (!hsync) begin
        cnt_a++;
        if (first_lo < 0) first_lo = c;
        last_lo = c;
      end
      if (line_start) cnt_b++;
      if (c < 800) tick();
    end
    check("line hsync low count", cnt_a, 96);
    check("line hsync first low", first_lo, 656);
    check("line hsync last low", last_lo, 751);
    check("line line_start count", cnt_b, 2);
    check("line vpos at 800", vpos, 1);

    // Random ena against the model.
    n = 800;
    for (int k = 0; k < 12000; k++) begin
      ena = ($urandom_range(0, 3) != 0);
      tick();
      if (ena) n++;
      check_all("rand", model(n));
    end

    // Alternating ena for one line: 1600 clocks, nothing moves on held cycles.
    jump(0, 5, 0, 0);
    n = 5 * 800;
    for (int k = 0; k < 1600; k++) begin
      ena = (k % 2 == 0);
      tick();
      if (ena) n++;
      check_all("toggle", model(n));
    end
    check("toggle end hpos", hpos, 0);
    check("toggle end vpos", vpos, 6);

    // Frame boundary: frame increments once with a single frame_start pulse.
    jump(790, 524, 0, 3);
    n     = 524 * 800 + 790;
    cnt_a = 0;
    ena   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      check_all("fwrap", model(n));
      if (frame_start) cnt_a++;
    end
    check("fwrap frame_start pulses", cnt_a, 1);
    check("fwrap frame", frame, 1);

    // Vertical sync spans exactly two lines.
    jump(0, 488, 1, 3);
    n     = 420000 + 488 * 800;
    cnt_a = 0;
    ena   = 1'b1;
    for (int k = 0; k < 3200; k++) begin
      tick();
      n++;
      check_all("vsync", model(n));
      if (!vsync) cnt_a++;
    end
    check("vsync low cycles", cnt_a, 1600);

    // All three counters wrap on the same edge, including frame 2047 -> 0.
    jump(799, 524, 2047, 3);
    ena = 1'b1;
    tick();
    check("max wrap hpos", hpos, 0);
    check("max wrap vpos", vpos, 0);
    check("max wrap frame", frame, 0);
    check("max wrap band", band, 0);
    check("max wrap frame_start", frame_start, 1);

    // Band steps at lines 120, 240 and 360.
    for (int b = 1; b <= 3; b++) begin
      jump(795, b * 120 - 1, 0, b - 1);
      n   = (b * 120 - 1) * 800 + 795;
      ena = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        n++;
        check_all($sformatf("band%0d", b), model(n));
      end
      check($sformatf("band%0d after step", b), band, b);
    end

    // Scan every line start of a frame: grad_step fires on 521 lines.
    cnt_a = 0;
    for (int v = 0; v < 525; v++) begin
      e = model(v * 800);
      jump(0, v, 0, e.bd);
      check_all("scan", e);
      if (grad_step) cnt_a++;
    end
    check("scan grad_step lines", cnt_a, 521);

    // Asynchronous reset mid-frame clears counters before the next edge.
    jump(290, 200, 0, 1);
    ena = 1'b1;
    repeat (10) tick();
    check("pre-reset hpos", hpos, 300);
    check("pre-reset vpos", vpos, 200);
    #2;
    reset = 1'b1;
    #1;
    e = model(0);
    check_all("async rst", e);
    tick();
    tick();
    check_all("rst held", e);
    reset = 1'b0;
    ena   = 1'b1;
    #1;
    check_all("rst released", e);
    tick();
    check_all("resume", model(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
